// File: rtl/uart_pkg.sv
// Shared types for the UART receive path: parity selection, receiver states
// and the per-word error flags carried alongside each received word.
package uart_pkg;

    typedef enum logic [1:0] {
        PARITY_NONE,
        PARITY_EVEN,
        PARITY_ODD
    } parity_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_HIGH
    } rx_state_t;

    // parity_err lands in bit 1 and framing_err in bit 0 of tuser.
    typedef struct packed {
        logic parity_err;
        logic framing_err;
    } rx_flags_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Stream port carrying received words and their error flags to the consumer.
interface uart_rx_fifo_if #(
    parameter int data_width = 8
);
    // A beat transfers on every clk edge where tvalid && tready; tvalid never
    // depends on tready, and tdata/tuser hold steady while tvalid waits.
    logic                  tvalid;
    logic                  tready;
    logic [data_width-1:0] tdata;
    logic [1:0]            tuser;
    logic                  overflow;

    modport master (output tvalid, output tdata, output tuser, output overflow, input tready);
    modport slave  (input tvalid, input tdata, input tuser, input overflow, output tready);

endinterface

// File: rtl/uart_fifo.sv
// First-word-fall-through FIFO: dout shows the head entry whenever empty is low.
module uart_fifo #(
    parameter int width = 10,
    parameter int depth = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [width-1:0] din,
    input  logic             pop,
    output logic [width-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(depth);

    logic [width-1:0] mem [depth];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // The extra pointer bit separates full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with 3-sample majority voting per bit, optional parity and
// stop-bit checking, feeding a FWFT FIFO that drives a valid/ready stream.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int cycles_per_bit = 434,
    parameter int data_width     = 8,
    parameter int parity_mode    = 0,
    parameter int stop_bits      = 1,
    parameter int fifo_depth     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    uart_rx_fifo_if.master    axis,
    output rx_state_t         state_dbg
);
    localparam int      H         = cycles_per_bit / 2;
    localparam int      CW        = $clog2(cycles_per_bit);
    localparam parity_t PMODE     = parity_t'(parity_mode);
    localparam logic [CW-1:0] CNT_LAST = CW'(cycles_per_bit - 1);
    localparam logic [CW-1:0] SMP_A    = CW'(H - 1);
    localparam logic [CW-1:0] SMP_B    = CW'(H);
    localparam logic [CW-1:0] SMP_C    = CW'(H + 1);
    localparam logic [3:0]    BIT_LAST  = 4'(data_width - 1);
    localparam logic          STOP_LAST = 1'(stop_bits - 1);

    logic sync1, rxs, rxs_d;
    rx_state_t state, state_next;
    logic [CW-1:0]         cnt;
    logic                  s0, s1;
    logic [data_width-1:0] shreg;
    logic [3:0]            bit_idx;
    logic                  stop_idx;
    logic                  par_err, ferr;
    logic                  fall, bit_end, at_res, maj, ferr_now, push;
    rx_flags_t             flags;
    logic                  fifo_full, fifo_empty, pop, overflow_q;
    logic [data_width+1:0] fifo_dout;

    // rxs_d resets low so a start edge is only seen after rxs has been high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
            rxs_d <= 1'b0;
        end else begin
            sync1 <= rx;
            rxs   <= sync1;
            rxs_d <= rxs;
        end
    end

    assign fall     = rxs_d & ~rxs;
    assign bit_end  = (cnt == CNT_LAST);
    assign at_res   = (cnt == SMP_C);
    assign maj      = majority3(s0, s1, rxs);
    assign ferr_now = ferr | ~maj;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        push       = 1'b0;
        case (state)
            ST_IDLE:      if (fall) state_next = ST_START;
            ST_START: begin
                if (at_res && maj) state_next = ST_IDLE;
                else if (bit_end)  state_next = ST_DATA;
            end
            ST_DATA: begin
                if (bit_end && bit_idx == BIT_LAST)
                    state_next = (PMODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
            end
            ST_PARITY:    if (bit_end) state_next = ST_STOP;
            ST_STOP: begin
                // The word leaves at the last stop bit's vote, so a new start
                // edge can follow straight away.
                if (at_res && stop_idx == STOP_LAST) begin
                    push       = 1'b1;
                    state_next = ferr_now ? ST_WAIT_HIGH : ST_IDLE;
                end
            end
            ST_WAIT_HIGH: if (rxs) state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            s0       <= 1'b1;
            s1       <= 1'b1;
            shreg    <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            par_err  <= 1'b0;
            ferr     <= 1'b0;
        end else begin
            if (state_next != state || bit_end || state == ST_IDLE || state == ST_WAIT_HIGH)
                cnt <= '0;
            else
                cnt <= cnt + CW'(1);
            if (cnt == SMP_A) s0 <= rxs;
            if (cnt == SMP_B) s1 <= rxs;
            case (state)
                ST_IDLE: begin
                    bit_idx  <= '0;
                    stop_idx <= 1'b0;
                    par_err  <= 1'b0;
                    ferr     <= 1'b0;
                end
                ST_DATA: begin
                    if (at_res)  shreg   <= {maj, shreg[data_width-1:1]};
                    if (bit_end) bit_idx <= bit_idx + 4'd1;
                end
                ST_PARITY: begin
                    if (at_res) par_err <= ((^shreg) ^ maj) != (PMODE == PARITY_ODD);
                end
                ST_STOP: begin
                    if (at_res)  ferr     <= ferr_now;
                    if (bit_end) stop_idx <= stop_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign flags.parity_err  = par_err;
    assign flags.framing_err = ferr_now;
    assign pop = axis.tvalid && axis.tready;

    uart_fifo #(
        .width (data_width + 2),
        .depth (fifo_depth)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   ({flags, shreg}),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // A simultaneous pop frees the slot, so only an unaided push to a full FIFO drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) overflow_q <= 1'b0;
        else     overflow_q <= push && fifo_full && !pop;
    end

    assign axis.tvalid            = ~fifo_empty;
    assign {axis.tuser, axis.tdata} = fifo_dout;
    assign axis.overflow          = overflow_q;
    assign state_dbg              = state;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: an 8N1 instance and an 8E1 instance, each
// with an expected-word queue checked whenever a beat is accepted.
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int CPB = 16;

    logic      clk = 1'b0;
    logic      rst = 1'b1;
    logic      rx_n = 1'b1;
    logic      rx_p = 1'b1;
    rx_state_t st_n, st_p;

    uart_rx_fifo_if #(.data_width(8)) axis_n ();
    uart_rx_fifo_if #(.data_width(8)) axis_p ();

    uart_rx_fifo #(
        .cycles_per_bit(CPB), .data_width(8), .parity_mode(0), .stop_bits(1), .fifo_depth(4)
    ) dut_n (
        .clk(clk), .rst(rst), .rx(rx_n), .axis(axis_n), .state_dbg(st_n)
    );

    uart_rx_fifo #(
        .cycles_per_bit(CPB), .data_width(8), .parity_mode(1), .stop_bits(1), .fifo_depth(4)
    ) dut_p (
        .clk(clk), .rst(rst), .rx(rx_p), .axis(axis_p), .state_dbg(st_p)
    );

    always #5 clk = ~clk;

    logic [9:0] exp_q_n[$];
    logic [9:0] exp_q_p[$];
    int n_vec = 0;
    int n_err = 0;
    int ovf_n = 0;
    int ovf_p = 0;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard: every accepted beat must match the oldest expected word.
    always @(negedge clk) begin
        if (axis_n.tvalid && axis_n.tready) begin
            if (exp_q_n.size() == 0) begin
                n_vec++;
                n_err++;
                $error("FAIL beat_n got %h expected no beat", {axis_n.tuser, axis_n.tdata});
            end else begin
                chk("beat_n", {6'd0, axis_n.tuser, axis_n.tdata}, {6'd0, exp_q_n.pop_front()});
            end
        end
        if (axis_p.tvalid && axis_p.tready) begin
            if (exp_q_p.size() == 0) begin
                n_vec++;
                n_err++;
                $error("FAIL beat_p got %h expected no beat", {axis_p.tuser, axis_p.tdata});
            end else begin
                chk("beat_p", {6'd0, axis_p.tuser, axis_p.tdata}, {6'd0, exp_q_p.pop_front()});
            end
        end
        if (axis_n.overflow) ovf_n++;
        if (axis_p.overflow) ovf_p++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_rx(input bit sel, input logic v);
        if (sel) rx_p = v;
        else     rx_n = v;
    endtask

    // A glitch inverts the line for the one cycle feeding the middle vote.
    task automatic send_bit(input bit sel, input logic v, input bit glitch);
        set_rx(sel, v);
        if (glitch) begin
            tick(9);
            set_rx(sel, ~v);
            tick(1);
            set_rx(sel, v);
            tick(CPB - 10);
        end else begin
            tick(CPB);
        end
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] d, input int par_bit,
                              input logic stop_v, input int glitch_bit, input bit check_lat);
        if (check_lat) begin
            set_rx(sel, 1'b0);
            tick(2);
            chk("lat_idle", 16'(sel ? st_p : st_n), 16'(ST_IDLE));
            tick(1);
            chk("lat_start", 16'(sel ? st_p : st_n), 16'(ST_START));
            tick(CPB - 3);
        end else begin
            send_bit(sel, 1'b0, 1'b0);
        end
        for (int i = 0; i < 8; i++) send_bit(sel, d[i], i == glitch_bit);
        if (par_bit >= 0) send_bit(sel, par_bit[0], 1'b0);
        send_bit(sel, stop_v, 1'b0);
    endtask

    task automatic wait_drain(input bit sel, input int bound, input string tag);
        int k = 0;
        while (k < bound && ((sel ? exp_q_p.size() : exp_q_n.size()) != 0 ||
                             (sel ? axis_p.tvalid : axis_n.tvalid))) begin
            tick(1);
            k++;
        end
        chk(tag, {7'(sel ? exp_q_p.size() : exp_q_n.size()), 8'd0,
                  (sel ? axis_p.tvalid : axis_n.tvalid)}, 16'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        axis_n.tready = 1'b1;
        axis_p.tready = 1'b1;
        rst = 1'b1;
        tick(3);
        chk("rst_out_n", {4'd0, axis_n.tvalid, axis_n.overflow, axis_n.tuser, axis_n.tdata}, 16'd0);
        chk("rst_out_p", {4'd0, axis_p.tvalid, axis_p.overflow, axis_p.tuser, axis_p.tdata}, 16'd0);
        chk("rst_state", {5'd0, st_n, 5'd0, st_p}, {5'd0, ST_IDLE, 5'd0, ST_IDLE});
        rst = 1'b0;
        tick(4);

        // Clean 8N1 word, with start-edge latency checked on the way.
        exp_q_n.push_back({2'b00, 8'h4D});
        send_frame(1'b0, 8'h4D, -1, 1'b1, -1, 1'b1);
        wait_drain(1'b0, 50, "drain_4d");
        chk("ovf_4d", 16'(ovf_n), 16'd0);

        // Even parity: wrong parity bit flagged, correct one clean.
        exp_q_p.push_back({2'b10, 8'h07});
        send_frame(1'b1, 8'h07, 0, 1'b1, -1, 1'b0);
        exp_q_p.push_back({2'b00, 8'h07});
        send_frame(1'b1, 8'h07, 1, 1'b1, -1, 1'b0);
        wait_drain(1'b1, 50, "drain_par");
        chk("ovf_par", 16'(ovf_p), 16'd0);

        // Framing error, line then held low: one word only until rx recovers.
        exp_q_n.push_back({2'b01, 8'hA5});
        send_frame(1'b0, 8'hA5, -1, 1'b0, -1, 1'b0);
        tick(CPB);
        chk("wait_high", 16'(st_n), 16'(ST_WAIT_HIGH));
        tick(2 * CPB);
        wait_drain(1'b0, 10, "drain_ferr");
        rx_n = 1'b1;
        tick(CPB);
        chk("ferr_idle", 16'(st_n), 16'(ST_IDLE));
        exp_q_n.push_back({2'b00, 8'h33});
        send_frame(1'b0, 8'h33, -1, 1'b1, -1, 1'b0);
        wait_drain(1'b0, 50, "drain_33");

        // Fill the FIFO with the consumer stalled; the fifth word overflows.
        axis_n.tready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            exp_q_n.push_back({2'b00, 8'(i)});
            send_frame(1'b0, 8'(i), -1, 1'b1, -1, 1'b0);
        end
        chk("ovf_before", 16'(ovf_n), 16'd0);
        send_frame(1'b0, 8'h05, -1, 1'b1, -1, 1'b0);
        chk("ovf_after", 16'(ovf_n), 16'd1);
        chk("head_full", {5'd0, axis_n.tvalid, axis_n.tuser, axis_n.tdata}, {5'd0, 1'b1, 2'b00, 8'h01});
        tick(CPB);
        axis_n.tready = 1'b1;
        wait_drain(1'b0, 20, "drain_ovf");
        chk("ovf_final", 16'(ovf_n), 16'd1);

        // Short low pulse well under half a bit is a false start.
        rx_n = 1'b0;
        tick(6);
        rx_n = 1'b1;
        tick(2 * CPB);
        chk("noise_idle", 16'(st_n), 16'(ST_IDLE));
        wait_drain(1'b0, 5, "noise_none");

        // Single-cycle glitch on the middle vote of data bit 2 is outvoted.
        exp_q_n.push_back({2'b00, 8'h3C});
        send_frame(1'b0, 8'h3C, -1, 1'b1, 2, 1'b0);
        wait_drain(1'b0, 50, "drain_3c");

        // Reset during data bit 4 with a word buffered.
        axis_n.tready = 1'b0;
        exp_q_n.push_back({2'b00, 8'h81});
        send_frame(1'b0, 8'h81, -1, 1'b1, -1, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0, 1'b0);
        rx_n = 1'b1;
        tick(5);
        chk("pre_rst", {5'd0, axis_n.tvalid, axis_n.tuser, axis_n.tdata}, {5'd0, 1'b1, 2'b00, 8'h81});
        rst = 1'b1;
        #1;
        chk("mid_rst_out", {4'd0, axis_n.tvalid, axis_n.overflow, axis_n.tuser, axis_n.tdata}, 16'd0);
        chk("mid_rst_state", 16'(st_n), 16'(ST_IDLE));
        exp_q_n.delete();
        tick(1);
        rst = 1'b0;
        axis_n.tready = 1'b1;
        tick(CPB - 6);
        for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b1, 1'b0);
        tick(CPB);
        wait_drain(1'b0, 5, "post_rst_none");
        exp_q_n.push_back({2'b00, 8'h5A});
        send_frame(1'b0, 8'h5A, -1, 1'b1, -1, 1'b0);
        wait_drain(1'b0, 50, "drain_5a");
        chk("ovf_end_p", 16'(ovf_p), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
